pll_reset_ctrl: RTL and testbench

Reset and lock supervisor for the clock-generation PLL. Runs on the 50 MHz board reference clock and drives the PLL's active-high `rst` input. Consumes the PLL's asynchronous `locked` output and releases a synchronous system reset only after lock has been held stable. On lock timeout or loss of lock it re-resets the PLL, and it counts both events for debug.

---
 rtl/pll_reset_ctrl.sv | 116 +++++++++++
 tb/tb_pll_reset_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_ctrl.sv
// PLL reset/lock supervisor: pulses the PLL reset, waits for a stable synchronized
// lock, then releases the system reset. Timeouts and lock losses are counted for debug.
module pll_reset_ctrl #(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 50000,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic [7:0] retry_cnt,
  output logic [7:0] lock_lost_cnt
);
  localparam int unsigned MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_CYC = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] PLL_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_PLL_RST   = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   locked_s;
  logic                   pll_rst_q, pll_rst_d;
  logic                   sys_rst_q, sys_rst_d;
  logic                   ready_q, ready_d;
  logic [7:0]             retry_q, retry_d;
  logic [7:0]             lost_q, lost_d;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign locked_s = sync_q[SYNC_STAGES-1];
  assign sync_d   = {sync_q[SYNC_STAGES-2:0], locked};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    retry_d = retry_q;
    lost_d  = lost_q;
    case (state_q)
      S_PLL_RST: begin
        if (cnt_q == PLL_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        // a lock arriving on the timeout cycle takes priority over the retry
        if (locked_s) begin
          state_d = S_STABLE;
        end else if (cnt_q == TMO_LAST) begin
          state_d = S_PLL_RST;
          retry_d = sat_inc(retry_q);
        end
      end
      S_STABLE: begin
        if (!locked_s)                  state_d = S_WAIT_LOCK;
        else if (cnt_q == STB_LAST)     state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d = '0;
        if (!locked_s) begin
          state_d = S_PLL_RST;
          lost_d  = sat_inc(lost_q);
        end
      end
      default: state_d = S_PLL_RST;
    endcase
    if (state_d != state_q) cnt_d = '0;

    // outputs are decoded from the next state so they change on the same edge
    pll_rst_d = (state_d == S_PLL_RST);
    sys_rst_d = (state_d != S_RUN);
    ready_d   = (state_d == S_RUN);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= S_PLL_RST;
      cnt_q     <= '0;
      sync_q    <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      retry_q   <= 8'd0;
      lost_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sync_q    <= sync_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
      retry_q   <= retry_d;
      lost_q    <= lost_d;
    end
  end

  assign pll_rst       = pll_rst_q;
  assign sys_rst       = sys_rst_q;
  assign ready         = ready_q;
  assign retry_cnt     = retry_q;
  assign lock_lost_cnt = lost_q;
endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Bench for pll_reset_ctrl: vector table, hand-built corner sequences and random
// lock activity, all checked against a phase/timestamp reference model.
module tb_pll_reset_ctrl;
  localparam int PRC = 4;
  localparam int LTO = 20;
  localparam int STC = 8;
  localparam int SYN = 2;

  localparam int PH_PULSE  = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_STABLE = 2;
  localparam int PH_RUN    = 3;

  logic       refclk = 1'b0;
  logic       rst    = 1'b1;
  logic       locked = 1'b0;
  logic       pll_rst, sys_rst, ready;
  logic [7:0] retry_cnt, lock_lost_cnt;

  int total = 0;
  int bad   = 0;

  pll_reset_ctrl #(
    .PLL_RST_CYCLES(PRC), .LOCK_TIMEOUT(LTO), .STABLE_CYCLES(STC), .SYNC_STAGES(SYN)
  ) dut (
    .refclk(refclk), .rst(rst), .locked(locked),
    .pll_rst(pll_rst), .sys_rst(sys_rst), .ready(ready),
    .retry_cnt(retry_cnt), .lock_lost_cnt(lock_lost_cnt)
  );

  always #5 refclk = ~refclk;

  // Reference model: phase plus the edge index at which it was entered; the
  // synchronizer is a plain delay queue.
  int cyc = 0;
  int m_phase = PH_PULSE;
  int m_start = 0;
  int m_retry = 0;
  int m_lost  = 0;
  bit lk_q[$];

  function void enter(input int ph);
    m_phase = ph;
    m_start = cyc;
  endfunction

  function void model_edge(input bit r, input bit l);
    bit lks;
    cyc++;
    if (r) begin
      enter(PH_PULSE);
      m_retry = 0;
      m_lost  = 0;
      lk_q.delete();
      for (int i = 0; i < SYN; i++) lk_q.push_back(1'b0);
      return;
    end
    lks = lk_q.pop_front();
    lk_q.push_back(l);
    case (m_phase)
      PH_PULSE:  if (cyc - m_start == PRC) enter(PH_WAIT);
      PH_WAIT: begin
        if (lks) enter(PH_STABLE);
        else if (cyc - m_start == LTO + 1) begin
          if (m_retry < 255) m_retry++;
          enter(PH_PULSE);
        end
      end
      PH_STABLE: begin
        if (!lks) enter(PH_WAIT);
        else if (cyc - m_start == STC) enter(PH_RUN);
      end
      default: begin
        if (!lks) begin
          if (m_lost < 255) m_lost++;
          enter(PH_PULSE);
        end
      end
    endcase
  endfunction

  task automatic step(input logic r, input logic l);
    logic [18:0] got, exp;
    rst    = r;
    locked = l;
    @(posedge refclk);
    model_edge(r, l);
    #1;
    got = {pll_rst, sys_rst, ready, retry_cnt, lock_lost_cnt};
    exp = {m_phase == PH_PULSE, m_phase != PH_RUN, m_phase == PH_RUN,
           8'(m_retry), 8'(m_lost)};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL model cyc=%0d got={pll,sys,rdy,retry,lost}=%h want=%h", cyc, got, exp);
    end
  endtask

  task automatic run(input logic r, input logic l, input int n);
    repeat (n) step(r, l);
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", nm, got, exp);
    end
  endtask

  typedef struct {
    logic r;
    logic l;
    int   n;
    logic e_pll;
    logic e_sys;
    logic e_rdy;
    int   e_retry;
    int   e_lost;
  } vec_t;

  localparam int NV = 28;

  initial begin
    vec_t tbl[NV];
    logic [18:0] got_v, exp_v;
    logic pll_seen;

    // bring-up, loss in RUN, reset mid-RUN, repeated timeouts
    tbl[0]  = '{1'b1, 1'b0,  3, 1'b1, 1'b1, 1'b0, 0, 0};
    tbl[1]  = '{1'b0, 1'b0,  3, 1'b1, 1'b1, 1'b0, 0, 0};
    tbl[2]  = '{1'b0, 1'b0,  1, 1'b0, 1'b1, 1'b0, 0, 0};
    tbl[3]  = '{1'b0, 1'b0,  5, 1'b0, 1'b1, 1'b0, 0, 0};
    tbl[4]  = '{1'b0, 1'b1, 10, 1'b0, 1'b1, 1'b0, 0, 0};
    tbl[5]  = '{1'b0, 1'b1,  1, 1'b0, 1'b0, 1'b1, 0, 0};
    tbl[6]  = '{1'b0, 1'b1, 20, 1'b0, 1'b0, 1'b1, 0, 0};
    tbl[7]  = '{1'b0, 1'b0,  2, 1'b0, 1'b0, 1'b1, 0, 0};
    tbl[8]  = '{1'b0, 1'b0,  1, 1'b1, 1'b1, 1'b0, 0, 1};
    tbl[9]  = '{1'b0, 1'b1,  3, 1'b1, 1'b1, 1'b0, 0, 1};
    tbl[10] = '{1'b0, 1'b1,  1, 1'b0, 1'b1, 1'b0, 0, 1};
    tbl[11] = '{1'b0, 1'b1,  8, 1'b0, 1'b1, 1'b0, 0, 1};
    tbl[12] = '{1'b0, 1'b1,  1, 1'b0, 1'b0, 1'b1, 0, 1};
    tbl[13] = '{1'b1, 1'b1,  1, 1'b1, 1'b1, 1'b0, 0, 0};
    tbl[14] = '{1'b0, 1'b1,  3, 1'b1, 1'b1, 1'b0, 0, 0};
    tbl[15] = '{1'b0, 1'b1,  1, 1'b0, 1'b1, 1'b0, 0, 0};
    tbl[16] = '{1'b0, 1'b1,  8, 1'b0, 1'b1, 1'b0, 0, 0};
    tbl[17] = '{1'b0, 1'b1,  1, 1'b0, 1'b0, 1'b1, 0, 0};
    tbl[18] = '{1'b1, 1'b0,  1, 1'b1, 1'b1, 1'b0, 0, 0};
    tbl[19] = '{1'b0, 1'b0,  4, 1'b0, 1'b1, 1'b0, 0, 0};
    tbl[20] = '{1'b0, 1'b0, 20, 1'b0, 1'b1, 1'b0, 0, 0};
    tbl[21] = '{1'b0, 1'b0,  1, 1'b1, 1'b1, 1'b0, 1, 0};
    tbl[22] = '{1'b0, 1'b0,  3, 1'b1, 1'b1, 1'b0, 1, 0};
    tbl[23] = '{1'b0, 1'b0,  1, 1'b0, 1'b1, 1'b0, 1, 0};
    tbl[24] = '{1'b0, 1'b0, 20, 1'b0, 1'b1, 1'b0, 1, 0};
    tbl[25] = '{1'b0, 1'b0,  1, 1'b1, 1'b1, 1'b0, 2, 0};
    tbl[26] = '{1'b0, 1'b0, 25, 1'b1, 1'b1, 1'b0, 3, 0};
    tbl[27] = '{1'b0, 1'b0, 15, 1'b0, 1'b1, 1'b0, 3, 0};

    for (int i = 0; i < NV; i++) begin
      run(tbl[i].r, tbl[i].l, tbl[i].n);
      got_v = {pll_rst, sys_rst, ready, retry_cnt, lock_lost_cnt};
      exp_v = {tbl[i].e_pll, tbl[i].e_sys, tbl[i].e_rdy, 8'(tbl[i].e_retry), 8'(tbl[i].e_lost)};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL vec%0d: got={pll,sys,rdy,retry,lost}=%h want=%h", i, got_v, exp_v);
      end
    end

    // lock glitch midway through stabilization: back to waiting, full restart
    run(1, 1, 1);
    run(0, 1, 7);
    run(0, 0, 3);
    chk("glitch_sys", int'(sys_rst), 1);
    pll_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(0, 1);
      pll_seen = pll_seen | pll_rst;
    end
    chk("glitch_no_pulse", int'(pll_seen), 0);
    chk("glitch_not_yet", int'(ready), 0);
    step(0, 1);
    chk("glitch_release", int'(ready), 1);
    chk("glitch_retry", int'(retry_cnt), 0);
    chk("glitch_lost", int'(lock_lost_cnt), 0);

    // lock drops exactly on the last stability cycle
    run(1, 1, 1);
    run(0, 1, 10);
    run(0, 0, 1);
    run(0, 1, 2);
    chk("stable_last_ready", int'(ready), 0);
    chk("stable_last_sys", int'(sys_rst), 1);
    run(0, 1, 8);
    chk("stable_restart_wait", int'(ready), 0);
    step(0, 1);
    chk("stable_restart_run", int'(ready), 1);

    // lock arrives exactly on the timeout cycle
    run(1, 0, 1);
    run(0, 0, 22);
    run(0, 1, 2);
    step(0, 1);
    chk("timeout_race_pll", int'(pll_rst), 0);
    chk("timeout_race_retry", int'(retry_cnt), 0);
    run(0, 1, 7);
    chk("timeout_race_wait", int'(ready), 0);
    step(0, 1);
    chk("timeout_race_run", int'(ready), 1);

    // 300 lock losses: counter saturates and holds
    for (int k = 0; k < 300; k++) begin
      run(0, 0, 1);
      run(0, 1, 15);
    end
    chk("sat_lost", int'(lock_lost_cnt), 255);
    chk("sat_ready", int'(ready), 1);
    run(0, 0, 1);
    run(0, 1, 15);
    chk("sat_hold", int'(lock_lost_cnt), 255);

    // random lock activity with occasional resets
    for (int s = 0; s < 200; s++) begin
      logic l;
      l = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 39) == 0) run(1, l, $urandom_range(1, 2));
      else                            run(0, l, $urandom_range(1, 30));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
